// File: rtl/oflow_score_board.sv
// oflow_score_board
//   Score-board storage between the PE similarity-metric outputs and the
//   conflict-resolve FSM. It holds one (score, id, valid, pointer) entry per
//   (row, PE).
//   Sequence: IDLE -> FILL (PEs write entries) -> CR_WAIT (the resolver reads
//   entries and writes pointers) -> DRAIN (pointer-marked entries are streamed
//   out over valid/ready) -> IDLE.
//
// Ports
//   clk, reset_N                  clock, asynchronous active-low reset
//   start_fill                    pulse: clear the board and open FILL
//   wr_valid/wr_pe/wr_score/wr_id PE entry write
//   fill_done                     pulse: all PEs finished
//   start_cr                      one-cycle pulse on entering CR_WAIT
//   done_cr                       resolver finished
//   row_sel/pe_sel                combinational read address
//   score_to_cr/id_to_cr          read data (all-ones / 0 when not valid)
//   row_to_change/pe_to_change    pointer write address
//   data_to_score_board           pointer write value
//   write_to_pointer              pointer write strobe
//   out_valid/out_ready           drain handshake
//   out_id/out_row/out_pe         drained entry
//   frame_done                    one-cycle pulse when the drain completes
//   overflow                      sticky: a fill write was dropped
//
// Build option
//   OFLOW_SB_POINTER_UNIQUE_EN: a pointer write of 1 also clears the pointer
//   of every other valid entry that holds the same id.

module oflow_score_board #(
  parameter int PE_NUM    = 8,
  parameter int ROWS      = 4,
  parameter int PE_LEN    = 4,
  parameter int ROW_LEN   = 3,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_fill,
  input  logic                 wr_valid,
  input  logic [PE_LEN-1:0]    wr_pe,
  input  logic [SCORE_LEN-1:0] wr_score,
  input  logic [ID_LEN-1:0]    wr_id,
  input  logic                 fill_done,
  output logic                 start_cr,
  input  logic                 done_cr,
  input  logic [ROW_LEN-1:0]   row_sel,
  input  logic [PE_LEN-1:0]    pe_sel,
  output logic [SCORE_LEN-1:0] score_to_cr,
  output logic [ID_LEN-1:0]    id_to_cr,
  input  logic [ROW_LEN-1:0]   row_to_change,
  input  logic [PE_LEN-1:0]    pe_to_change,
  input  logic                 data_to_score_board,
  input  logic                 write_to_pointer,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_LEN-1:0]    out_id,
  output logic [ROW_LEN-1:0]   out_row,
  output logic [PE_LEN-1:0]    out_pe,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int PE_IW  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int ROW_IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [PE_LEN-1:0]  PE_MAX   = PE_LEN'(PE_NUM);
  localparam logic [PE_LEN-1:0]  PE_LAST  = PE_LEN'(PE_NUM - 1);
  localparam logic [ROW_LEN-1:0] ROW_MAX  = ROW_LEN'(ROWS);
  localparam logic [ROW_LEN-1:0] ROW_LAST = ROW_LEN'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CR_WAIT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SCORE_LEN-1:0] r_score    [ROWS][PE_NUM];
  logic [ID_LEN-1:0]    r_id       [ROWS][PE_NUM];
  logic                 r_valid    [ROWS][PE_NUM];
  logic                 r_ptr      [ROWS][PE_NUM];
  logic [ROW_LEN-1:0]   r_fill_cnt [PE_NUM];

  logic                 r_start_cr;
  logic                 r_frame_done;
  logic                 r_overflow;
  logic [ROW_LEN-1:0]   r_scan_row;
  logic [PE_LEN-1:0]    r_scan_pe;

  // Fill write path
  logic                 w_wr_in_range;
  logic [PE_IW-1:0]     w_wr_pe;
  logic [ROW_LEN-1:0]   w_wr_cnt;
  logic [ROW_IW-1:0]    w_wr_row;
  logic                 w_wr_ok;

  assign w_wr_in_range = (wr_pe < PE_MAX);
  assign w_wr_pe       = wr_pe[PE_IW-1:0];
  assign w_wr_cnt      = r_fill_cnt[w_wr_pe];
  assign w_wr_row      = w_wr_cnt[ROW_IW-1:0];
  assign w_wr_ok       = w_wr_in_range && (w_wr_cnt != ROW_MAX);

  // Combinational read path
  logic                 w_rd_in_range;
  logic [ROW_IW-1:0]    w_rd_row;
  logic [PE_IW-1:0]     w_rd_pe;
  logic                 w_rd_hit;

  assign w_rd_in_range = (row_sel < ROW_MAX) && (pe_sel < PE_MAX);
  assign w_rd_row      = row_sel[ROW_IW-1:0];
  assign w_rd_pe       = pe_sel[PE_IW-1:0];
  assign w_rd_hit      = w_rd_in_range && r_valid[w_rd_row][w_rd_pe];
  assign score_to_cr   = w_rd_hit ? r_score[w_rd_row][w_rd_pe] : '1;
  assign id_to_cr      = w_rd_hit ? r_id[w_rd_row][w_rd_pe] : '0;

  // Pointer write path
  logic                 w_pw_in_range;
  logic [ROW_IW-1:0]    w_pw_row;
  logic [PE_IW-1:0]     w_pw_pe;
  logic                 w_pw_ok;

  assign w_pw_in_range = (row_to_change < ROW_MAX) && (pe_to_change < PE_MAX);
  assign w_pw_row      = row_to_change[ROW_IW-1:0];
  assign w_pw_pe       = pe_to_change[PE_IW-1:0];
  assign w_pw_ok       = (r_state == S_CR_WAIT) && write_to_pointer &&
                         w_pw_in_range && r_valid[w_pw_row][w_pw_pe];

`ifdef OFLOW_SB_POINTER_UNIQUE_EN
  logic [ID_LEN-1:0]    w_pw_id;
  assign w_pw_id = r_id[w_pw_row][w_pw_pe];
`endif

  // Drain scan
  logic [ROW_IW-1:0]    w_scan_r;
  logic [PE_IW-1:0]     w_scan_p;
  logic                 w_scan_hit;
  logic                 w_scan_last;
  logic                 w_drain_adv;
  logic                 w_drain_end;

  assign w_scan_r    = r_scan_row[ROW_IW-1:0];
  assign w_scan_p    = r_scan_pe[PE_IW-1:0];
  assign w_scan_hit  = r_valid[w_scan_r][w_scan_p] && r_ptr[w_scan_r][w_scan_p];
  assign w_scan_last = (r_scan_row == ROW_LAST) && (r_scan_pe == PE_LAST);
  // A marked entry holds the scan until the downstream accepts it.
  assign w_drain_adv = (r_state == S_DRAIN) && (!w_scan_hit || out_ready);
  assign w_drain_end = w_drain_adv && w_scan_last;

  assign out_valid  = (r_state == S_DRAIN) && w_scan_hit;
  assign out_id     = out_valid ? r_id[w_scan_r][w_scan_p] : '0;
  assign out_row    = out_valid ? r_scan_row : '0;
  assign out_pe     = out_valid ? r_scan_pe : '0;
  assign start_cr   = r_start_cr;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

  // State register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_fill)  w_state_nxt = S_FILL;
      S_FILL:    if (fill_done)   w_state_nxt = S_CR_WAIT;
      S_CR_WAIT: if (done_cr)     w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_drain_end) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Board storage and fill counters
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned p = 0; p < PE_NUM; p++) begin
          r_score[r][p] <= '1;
          r_id[r][p]    <= '0;
          r_valid[r][p] <= 1'b0;
          r_ptr[r][p]   <= 1'b0;
        end
      end
      for (int unsigned p = 0; p < PE_NUM; p++) begin
        r_fill_cnt[p] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_fill) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
              for (int unsigned p = 0; p < PE_NUM; p++) begin
                r_score[r][p] <= '1;
                r_id[r][p]    <= '0;
                r_valid[r][p] <= 1'b0;
                r_ptr[r][p]   <= 1'b0;
              end
            end
            for (int unsigned p = 0; p < PE_NUM; p++) begin
              r_fill_cnt[p] <= '0;
            end
          end
        end
        S_FILL: begin
          if (wr_valid && w_wr_ok) begin
            r_score[w_wr_row][w_wr_pe] <= wr_score;
            r_id[w_wr_row][w_wr_pe]    <= wr_id;
            r_valid[w_wr_row][w_wr_pe] <= 1'b1;
            r_ptr[w_wr_row][w_wr_pe]   <= 1'b0;
            r_fill_cnt[w_wr_pe]        <= w_wr_cnt + ROW_LEN'(1);
          end
        end
        S_CR_WAIT: begin
          if (w_pw_ok) begin
`ifdef OFLOW_SB_POINTER_UNIQUE_EN
            // The sweep also hits the addressed entry (same id); the
            // addressed assignment below comes later and therefore wins.
            if (data_to_score_board) begin
              for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned p = 0; p < PE_NUM; p++) begin
                  if (r_valid[r][p] && (r_id[r][p] == w_pw_id)) begin
                    r_ptr[r][p] <= 1'b0;
                  end
                end
              end
            end
`endif
            r_ptr[w_pw_row][w_pw_pe] <= data_to_score_board;
          end
        end
        default: ;
      endcase
    end
  end

  // Control pulses, overflow flag and drain scan index
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_start_cr   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_scan_row   <= '0;
      r_scan_pe    <= '0;
    end else begin
      r_start_cr   <= (r_state == S_FILL) && fill_done;
      r_frame_done <= w_drain_end;
      if ((r_state == S_IDLE) && start_fill) begin
        r_overflow <= 1'b0;
      end else if ((r_state == S_FILL) && wr_valid && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (w_drain_adv) begin
        if (w_scan_last) begin
          r_scan_row <= '0;
          r_scan_pe  <= '0;
        end else if (r_scan_pe == PE_LAST) begin
          r_scan_pe  <= '0;
          r_scan_row <= r_scan_row + ROW_LEN'(1);
        end else begin
          r_scan_pe  <= r_scan_pe + PE_LEN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_oflow_score_board.sv
module tb_oflow_score_board;

  logic        clk;
  logic        reset_N;
  logic        start_fill;
  logic        wr_valid;
  logic [3:0]  wr_pe;
  logic [15:0] wr_score;
  logic [11:0] wr_id;
  logic        fill_done;
  logic        start_cr;
  logic        done_cr;
  logic [2:0]  row_sel;
  logic [3:0]  pe_sel;
  logic [15:0] score_to_cr;
  logic [11:0] id_to_cr;
  logic [2:0]  row_to_change;
  logic [3:0]  pe_to_change;
  logic        data_to_score_board;
  logic        write_to_pointer;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_id;
  logic [2:0]  out_row;
  logic [3:0]  out_pe;
  logic        frame_done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  oflow_score_board #(
    .PE_NUM(8), .ROWS(4), .PE_LEN(4), .ROW_LEN(3), .SCORE_LEN(16), .ID_LEN(12)
  ) dut (
    .clk(clk), .reset_N(reset_N), .start_fill(start_fill),
    .wr_valid(wr_valid), .wr_pe(wr_pe), .wr_score(wr_score), .wr_id(wr_id),
    .fill_done(fill_done), .start_cr(start_cr), .done_cr(done_cr),
    .row_sel(row_sel), .pe_sel(pe_sel), .score_to_cr(score_to_cr), .id_to_cr(id_to_cr),
    .row_to_change(row_to_change), .pe_to_change(pe_to_change),
    .data_to_score_board(data_to_score_board), .write_to_pointer(write_to_pointer),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_row(out_row), .out_pe(out_pe), .frame_done(frame_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the board as plain arrays plus per-PE fill counts.
  logic [15:0] m_score [4][8];
  logic [11:0] m_id    [4][8];
  bit          m_valid [4][8];
  bit          m_ptr   [4][8];
  int          m_cnt   [8];
  bit          m_ovf;
  bit          m_scr;

  typedef struct {
    int          row;
    int          pe;
    logic [11:0] id;
  } ent_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_fill = 0; wr_valid = 0; wr_pe = 0; wr_score = 0; wr_id = 0;
    fill_done = 0; done_cr = 0; row_sel = 0; pe_sel = 0;
    row_to_change = 0; pe_to_change = 0; data_to_score_board = 0;
    write_to_pointer = 0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 8; p++) begin
        m_score[r][p] = 16'hFFFF; m_id[r][p] = 12'h0;
        m_valid[r][p] = 0; m_ptr[r][p] = 0;
      end
    for (int p = 0; p < 8; p++) m_cnt[p] = 0;
    m_ovf = 0;
  endtask

  function automatic logic [15:0] exp_score(input int r, input int p);
    if (r < 4 && p < 8 && m_valid[r][p]) return m_score[r][p];
    return 16'hFFFF;
  endfunction

  function automatic logic [11:0] exp_id(input int r, input int p);
    if (r < 4 && p < 8 && m_valid[r][p]) return m_id[r][p];
    return 12'h0;
  endfunction

  task automatic model_ptr_write(input int r, input int p, input bit d);
    if (r < 4 && p < 8 && m_valid[r][p]) begin
`ifdef OFLOW_SB_POINTER_UNIQUE_EN
      if (d)
        for (int rr = 0; rr < 4; rr++)
          for (int pp = 0; pp < 8; pp++)
            if (m_valid[rr][pp] && m_id[rr][pp] == m_id[r][p] && !(rr == r && pp == p))
              m_ptr[rr][pp] = 0;
`endif
      m_ptr[r][p] = d;
    end
  endtask

  task automatic do_start_fill();
    start_fill = 1;
    tick();
    start_fill = 0;
    model_clear();
    #1;
    check("ovf_after_start", overflow, m_ovf);
  endtask

  // One FILL cycle; a pointer strobe here must be ignored.
  task automatic fill_write(input int pe, input logic [15:0] sc, input logic [11:0] id, input bit fd);
    wr_valid = 1; wr_pe = pe[3:0]; wr_score = sc; wr_id = id; fill_done = fd;
    write_to_pointer = ($urandom_range(0, 3) == 0); data_to_score_board = 1;
    row_to_change = 0; pe_to_change = 0;
    tick();
    wr_valid = 0; fill_done = 0; write_to_pointer = 0; data_to_score_board = 0;
    if (pe < 8 && m_cnt[pe] < 4) begin
      m_score[m_cnt[pe]][pe] = sc; m_id[m_cnt[pe]][pe] = id;
      m_valid[m_cnt[pe]][pe] = 1; m_ptr[m_cnt[pe]][pe] = 0;
      m_cnt[pe]++;
    end else begin
      m_ovf = 1;
    end
    if (fd) m_scr = 1;
    #1;
    check("ovf_fill", overflow, m_ovf);
  endtask

  task automatic fill_done_pulse();
    fill_done = 1;
    tick();
    fill_done = 0;
    m_scr = 1;
  endtask

  // One CR_WAIT cycle: read check (old data), optional pointer write, optional done_cr.
  task automatic cr_cycle(input int rr, input int rp, input bit pw, input int pr, input int pp,
                          input bit pd, input bit dcr, input bit noise);
    row_sel = rr[2:0]; pe_sel = rp[3:0];
    write_to_pointer = pw; row_to_change = pr[2:0]; pe_to_change = pp[3:0];
    data_to_score_board = pd; done_cr = dcr;
    if (noise) begin
      start_fill = 1; wr_valid = 1; wr_pe = 0; wr_score = 16'h1234; wr_id = 12'h777; fill_done = 1;
    end
    #1;
    check("start_cr", start_cr, m_scr);
    m_scr = 0;
    check("rd_score", score_to_cr, exp_score(rr, rp));
    check("rd_id", id_to_cr, exp_id(rr, rp));
    check("ovf_cr", overflow, m_ovf);
    check("outv_cr", out_valid, 0);
    tick();
    clear_inputs();
    if (pw) model_ptr_write(pr, pp, pd);
  endtask

  // Runs a whole DRAIN from its first cycle; stall0 = cycles of forced backpressure on valid.
  task automatic drain(input bit rnd, input int stall0);
    ent_t q[$];
    ent_t e;
    int   stalls = 0;
    int   stall_left = stall0;
    bit   done = 0;
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 8; p++)
        if (m_valid[r][p] && m_ptr[r][p]) begin
          e.row = r; e.pe = p; e.id = m_id[r][p];
          q.push_back(e);
        end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      if (frame_done) begin
        check("drain_len", cyc, 32 + stalls);
        check("drain_left", q.size(), 0);
        check("fd_outv", out_valid, 0);
        check("fd_outid", out_id, 0);
        done = 1;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          check("drain_extra", out_valid, 0);
        end else begin
          check("out_id", out_id, q[0].id);
          check("out_row", out_row, q[0].row);
          check("out_pe", out_pe, q[0].pe);
        end
        if (stall_left > 0) begin
          out_ready = 0; stall_left--;
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
        end else begin
          stalls++;
        end
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      tick();
    end
    out_ready = 0;
    if (!done) check("drain_timeout", frame_done, 1);
    #1;
    check("fd_pulse", frame_done, 0);
  endtask

  initial begin
    int n, k;
    bit fd;
    ent_t first;
    bit found;

    clear_inputs();
    out_ready = 0;
    m_scr = 0;
    model_clear();
    reset_N = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_cr", start_cr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_pe", out_pe, 0);
    check("rst_rd_score", score_to_cr, 16'hFFFF);
    check("rst_rd_id", id_to_cr, 0);
    reset_N = 1;
    tick();

    // Basic flow, simultaneous fill write + fill_done, same-cycle read/pointer write
    do_start_fill();
    fill_write(0, 16'h0010, 12'd5, 0);
    fill_write(1, 16'h0020, 12'd5, 0);
    fill_write(2, 16'h0005, 12'd9, 1);
    cr_cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cr_cycle(0, 3, 0, 0, 0, 0, 0, 0);
    cr_cycle(0, 2, 0, 0, 0, 0, 0, 0);
    cr_cycle(4, 0, 0, 0, 0, 0, 0, 0);
    cr_cycle(0, 8, 0, 0, 0, 0, 0, 0);
    cr_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cr_cycle(0, 0, 1, 0, 0, 1, 0, 0);
    cr_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cr_cycle(1, 0, 1, 1, 0, 1, 0, 0);
    cr_cycle(0, 1, 1, 0, 9, 1, 0, 0);
    cr_cycle(0, 2, 1, 0, 2, 1, 1, 0);
    drain(0, 3);

    // IDLE: board retained, control pulses ignored
    row_sel = 0; pe_sel = 0;
    #1;
    check("idle_rd_score", score_to_cr, 16'h0010);
    fill_done = 1; wr_valid = 1; wr_pe = 0; done_cr = 1;
    tick();
    clear_inputs();
    #1;
    check("idle_start_cr", start_cr, 0);
    check("idle_rd_keep", score_to_cr, 16'h0010);

    // Overflow on PE3
    do_start_fill();
    row_sel = 0; pe_sel = 0;
    #1;
    check("clr_rd_score", score_to_cr, 16'hFFFF);
    for (int i = 0; i < 5; i++) fill_write(3, 16'h0100 + 16'(i), 12'h020 + 12'(i), 0);
    fill_done_pulse();
    for (int r = 0; r < 5; r++) cr_cycle(r, 3, 0, 0, 0, 0, 0, 0);
    cr_cycle(3, 3, 1, 3, 3, 1, 1, 0);
    drain(1, 0);
    check("ovf_sticky", overflow, 1);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      do_start_fill();
      n = $urandom_range(5, 30);
      fd = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        fill_write($urandom_range(0, 9), 16'($urandom), 12'($urandom_range(0, 3)), fd && (i == n - 1));
        if ($urandom_range(0, 3) == 0 && i != n - 1) tick();
      end
      if (!fd) fill_done_pulse();
      k = $urandom_range(3, 15);
      for (int j = 0; j < k; j++)
        cr_cycle($urandom_range(0, 4), $urandom_range(0, 9), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 4), $urandom_range(0, 9), ($urandom_range(0, 3) != 0),
                 (j == k - 1), ($urandom_range(0, 7) == 0));
      drain(1, $urandom_range(0, 2));
      check("ovf_end", overflow, m_ovf);
    end

    // Duplicate id winners, then reset in the middle of DRAIN
    do_start_fill();
    fill_write(0, 16'h0010, 12'd5, 0);
    fill_write(1, 16'h0020, 12'd5, 1);
    cr_cycle(0, 0, 1, 0, 0, 1, 0, 0);
    cr_cycle(0, 0, 1, 0, 1, 1, 1, 0);
    found = 0;
    for (int r = 0; r < 4 && !found; r++)
      for (int p = 0; p < 8 && !found; p++)
        if (m_valid[r][p] && m_ptr[r][p]) begin
          first.row = r; first.pe = p; first.id = m_id[r][p]; found = 1;
        end
    out_ready = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_valid) break;
      tick();
    end
    check("rst_first_valid", out_valid, 1);
    check("rst_first_pe", out_pe, first.pe);
    check("rst_first_id", out_id, first.id);
    reset_N = 0;
    #1;
    model_clear();
    m_scr = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_id", out_id, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_rd_score", score_to_cr, 16'hFFFF);
    check("midrst_overflow", overflow, 0);
    tick();
    reset_N = 1;
    fill_done = 1; done_cr = 1;
    tick();
    clear_inputs();
    #1;
    check("postrst_start_cr", start_cr, 0);
    check("postrst_out_valid", out_valid, 0);
    do_start_fill();
    fill_write(5, 16'h0ABC, 12'h123, 1);
    cr_cycle(0, 5, 0, 0, 0, 0, 1, 0);
    drain(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oflow_score_board.md
Name: oflow_score_board

Overview:
- Score-board storage that sits between the PE similarity-metric outputs and the conflict-resolve FSM.
- Holds one (score, id, valid, pointer) entry per (row, PE).
- During FILL, PEs write entries into it.
- During CR it answers the resolver's combinational reads and accepts its pointer writes.
- During DRAIN it streams every pointer-marked entry to the downstream ID-assignment stage over a valid/ready handshake.

Parameters:
- PE_NUM, 8, number of PEs (columns).
- ROWS, 4, rows per PE (equals MAX_ROWS_IN_SCORE_BOARD).
- PE_LEN, 4, PE index width; must hold PE_NUM itself.
- ROW_LEN, 3, row index width; must hold ROWS itself.
- SCORE_LEN, 16, score width.
- ID_LEN, 12, object id width.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start_fill  in  1  pulse: clear board and open FILL.
- wr_valid  in  1  PE entry write strobe.
- wr_pe  in  PE_LEN  target PE.
- wr_score  in  SCORE_LEN  entry score.
- wr_id  in  ID_LEN  entry id.
- fill_done  in  1  pulse: all PEs finished.
- start_cr  out  1  one-cycle pulse to the resolver.
- done_cr  in  1  resolver finished.
- row_sel  in  ROW_LEN  read row.
- pe_sel  in  PE_LEN  read PE.
- score_to_cr  out  SCORE_LEN  read score (combinational).
- id_to_cr  out  ID_LEN  read id (combinational).
- row_to_change  in  ROW_LEN  pointer write row.
- pe_to_change  in  PE_LEN  pointer write PE.
- data_to_score_board  in  1  pointer value.
- write_to_pointer  in  1  pointer write strobe.
- out_valid  out  1  drain entry valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_LEN  drained id.
- out_row  out  ROW_LEN  drained row.
- out_pe  out  PE_LEN  drained PE.
- frame_done  out  1  one-cycle pulse, drain complete.
- overflow  out  1  sticky: a write was dropped because the target PE column was full.

Behaviour:
- Reset (asynchronous, active-low) forces IDLE and all of the following, from any state including mid-FILL or mid-DRAIN:
  - per-PE fill counters = 0
  - every entry valid = 0, pointer = 0, score = all-ones, id = 0
  - start_cr, out_valid, frame_done, overflow = 0
  - scan index = 0
- State machine: IDLE -> FILL -> CR_WAIT -> DRAIN -> IDLE.
- IDLE:
  - start_fill clears all entries to their reset values, clears the fill counters and overflow, and moves to FILL.
  - Every other input is ignored.
- FILL:
  - wr_valid with wr_pe < PE_NUM writes {score, id, valid = 1, pointer = 0} at (fill_cnt[wr_pe], wr_pe), then fill_cnt[wr_pe] increments.
  - If fill_cnt[wr_pe] == ROWS, or wr_pe >= PE_NUM, the write is dropped and overflow is set.
  - fill_done moves to CR_WAIT next cycle. If wr_valid and fill_done arrive in the same cycle, the write is still accepted.
- CR_WAIT:
  - start_cr is high for exactly the first cycle of CR_WAIT (registered pulse).
  - Read path is combinational, same cycle: a valid entry returns its score and id. An invalid entry, row_sel >= ROWS or pe_sel >= PE_NUM returns score = all-ones, id = 0.
  - write_to_pointer updates the addressed entry's pointer with data_to_score_board at the clock edge. Writes to invalid or out-of-range entries are ignored.
  - A read and a pointer write to the same entry in one cycle: the read returns the old data.
  - done_cr moves to DRAIN next cycle. Pointer writes arriving in the same cycle as done_cr are still applied.
- DRAIN:
  - The scan index walks row-major, idx = row*PE_NUM + pe, over 0..ROWS*PE_NUM-1.
  - Entry at idx not (valid && pointer): advance one index per cycle, out_valid = 0.
  - Entry at idx (valid && pointer): out_valid = 1 with out_id/out_row/out_pe stable. Hold until out_ready is sampled high, then advance.
  - After the last index: frame_done pulses for one cycle and the state returns to IDLE.
- Outside DRAIN, out_valid = 0 and out_* = 0.
- Control pulses outside their own state (start_fill, fill_done, done_cr, write_to_pointer) are ignored.

Optional Feature:
- Macro: OFLOW_SB_POINTER_UNIQUE_EN.
- Defined: a pointer write of 1 also clears, in the same edge, the pointer of every other valid entry holding the same id. This guarantees at most one winner per id.
  - If that same cycle's read targets a cleared entry, the read is unaffected.
- Undefined: a pointer write touches only the addressed entry. Duplicate winners are possible and are all drained.

Test Plan:
- Basic flow:
  - Stimulus: reset; start_fill; write PE0 (score 0x0010, id 5), PE1 (0x0020, id 5), PE2 (0x0005, id 9); fill_done.
  - Required: start_cr high for exactly 1 cycle; row_sel = 0, pe_sel = 1 reads 0x0020/5; pe_sel = 3 reads 0xFFFF/0.
- Overflow:
  - Stimulus: 5 writes to PE3 with ROWS = 4.
  - Required: rows 0-3 filled, 5th write dropped, overflow = 1, overflow stays 1 until the next start_fill.
- Drain with backpressure:
  - Stimulus: pointer writes to (0,0) = 1 and (0,2) = 1; done_cr; out_ready held low for 3 cycles, then high.
  - Required: out_valid holds id 5/row 0/pe 0 stable for 3 cycles; then id 9/row 0/pe 2 is emitted; frame_done pulses after index 31; state returns to IDLE.
- Same-cycle read and pointer write:
  - Stimulus: a pointer write and a read of the same entry in one cycle.
  - Required: the read returns the old data.
- Simultaneous edges:
  - Stimulus: wr_valid together with fill_done; a pointer write together with done_cr.
  - Required: both updates are applied; start_cr pulses once; DRAIN shows the written pointer.
- Reset mid-DRAIN with the feature:
  - Stimulus: with OFLOW_SB_POINTER_UNIQUE_EN defined, pointer (0,0) = 1 then (0,1) = 1, both id 5. Then assert reset_N = 0 during DRAIN.
  - Required: (0,0) pointer reads back 0 after the second write; only (0,1) drains. On reset, out_valid drops to 0 immediately and the state is IDLE.
